ram_wr_burst_16: RTL and testbench
==================================

Name: ram_wr_burst_16

Overview:
- Write-side counterpart of the 16-wide window-read weight/activation RAM in the fully-connected datapath.
- Accepts 16 parallel words (e.g. one layer's neuron outputs) in a single valid/ready handshake.
- Serialises them into the single-port write interface of the RAM (wren/waddr/din) as a 16-cycle burst at consecutive addresses.
- Base address comes either from the caller or from an internal running write pointer.

Parameters:
- DWIDTH, 16, data word width; must match the RAM's DWIDTH.
- AWIDTH, 8, RAM address width; must match the RAM's AWIDTH.
- NWORDS, 16, words per burst; fixed at 16, not meant to be overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  burst request valid.
- in_ready  output  1  block can accept a burst.
- in_data  input  NWORDS*DWIDTH  16 words; word k at bits [k*DWIDTH +: DWIDTH]; word 0 is written first.
- use_ptr  input  1  sampled with the handshake: 1 = use internal pointer as base, 0 = use base_addr.
- base_addr  input  AWIDTH  explicit base address when use_ptr = 0.
- ptr_clr  input  1  synchronous clear of the running pointer to 0.
- wren  output  1  RAM write enable.
- waddr  output  AWIDTH  RAM write address.
- din  output  DWIDTH  RAM write data.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last word is written.
- wr_ptr  output  AWIDTH  current running pointer.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; wren = 0, waddr = 0, din = 0, busy = 0, done = 0, in_ready = 0, wr_ptr = 0, word counter = 0, shadow regs = 0. wren must drop immediately on reset assertion, not at the next edge.
- First cycle after reset release: in_ready = 1.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_data into the shadow regs. Base = use_ptr ? wr_ptr : base_addr. Go to WRITE with cnt = 0.
  - WRITE: outputs are registered. In cycle k (k = 0..15): wren = 1, waddr = (base + k) mod 2^AWIDTH, din = word k. At k = 15 go to DONE.
  - DONE: wren = 0, done = 1 for exactly one cycle, wr_ptr <= (base + 16) mod 2^AWIDTH. Next state IDLE.
- Latency: wren is first high on the cycle after the accepting edge. 16 consecutive wren cycles with no gaps, then done. Accept-to-accept minimum is 18 cycles.
- in_ready = 1 only in IDLE. in_valid in any other state is ignored; no queuing.
- busy = 1 in WRITE and DONE.
- Address wrap: pure modulo 2^AWIDTH. With base = 250 and AWIDTH = 8, addresses run 250..255, 0..9, and wr_ptr becomes 10.
- wr_ptr also advances on explicit-base bursts, to base_addr + 16.
- ptr_clr:
  - In IDLE or WRITE: wr_ptr <= 0 next cycle; an in-flight burst keeps its latched base.
  - Coinciding with the DONE update: ptr_clr wins and wr_ptr = 0.
  - Coinciding with a handshake in IDLE: the accepted burst uses the pre-clear pointer value.
- Input stability: in_data, base_addr and use_ptr are only required to be stable on the accepting edge; later changes have no effect.
- Reset mid-burst: the burst is abandoned. Words already written stay in the RAM; no done pulse is generated.
- Counter is 4 bits. Terminal condition is cnt == NWORDS-1; there is no off-by-one extra write.

Decomposition:
- Shared package (fc_ram_pkg):
  - DWIDTH, AWIDTH, NWORDS constants, shared with the 16-wide read RAM.
  - State enum {IDLE, WRITE, DONE}.
  - Word-slice helper function.
- One natural sub-module: ram_wr_shreg.
  - 16-entry DWIDTH parallel-load shift register.
  - Loads on accept, shifts one word per WRITE cycle, presents word 0 at its head.
- FSM, counter and pointer stay in the top module.

Test Plan:
- Reset, then one burst with use_ptr = 0, base_addr = 0x20, word k = 0x1000 + k -> wren high for 16 cycles, waddr 0x20..0x2F, din 0x1000..0x100F, done on cycle 17, wr_ptr = 0x30.
- Two back-to-back pointer bursts from reset, words 0xA0+k then 0xB0+k, in_valid held high -> addresses 0x00..0x1F contiguous. in_ready low for 17 cycles between accepts. wr_ptr = 0x20.
- Wrap: base_addr = 250 -> waddr sequence 250..255, 0..9; wr_ptr = 10; the RAM's window read at raddr = 250 returns all 16 words in order.
- in_valid pulsed during WRITE with different data -> ignored; only the first burst's data appears on din.
- rst_n dropped at k = 5 -> wren = 0 immediately. After release: in_ready = 1, wr_ptr = 0, no done pulse.
- ptr_clr asserted during a pointer burst at base 0x40 -> burst completes at 0x40..0x4F; the done-cycle update and the clear combine so that wr_ptr = 0 after DONE.

Source files
------------

// File: rtl/fc_ram_pkg.sv
// Shared constants, FSM state type and word-slice helper for the
// fully-connected datapath RAM read/write blocks.
package fc_ram_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 8;
  localparam int NWORDS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [DWIDTH-1:0] word_slice(
    input logic [NWORDS*DWIDTH-1:0] bus,
    input int unsigned              k
  );
    return bus[k*DWIDTH +: DWIDTH];
  endfunction

endpackage

// File: rtl/ram_wr_shreg.sv
// Parallel-load shift register holding one burst; word 0 sits at the head
// and each shift exposes the next word, back-filling with zeros.
module ram_wr_shreg
  import fc_ram_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     shift,
  input  logic [NWORDS*DWIDTH-1:0] load_data,
  output logic [DWIDTH-1:0]        head
);

  logic [DWIDTH-1:0] regs_r [NWORDS];

  // Shadow storage: load wins over shift, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        regs_r[i] <= {DWIDTH{1'b0}};
      end
    end else if (load) begin
      for (int i = 0; i < NWORDS; i++) begin
        regs_r[i] <= word_slice(load_data, i);
      end
    end else if (shift) begin
      for (int i = 0; i < NWORDS - 1; i++) begin
        regs_r[i] <= regs_r[i+1];
      end
      regs_r[NWORDS-1] <= {DWIDTH{1'b0}};
    end
  end

  assign head = regs_r[0];

endmodule

// File: rtl/ram_wr_burst_16.sv
// Accepts 16 words in one handshake and writes them to a single-port RAM
// as a gap-free burst at consecutive (wrapping) addresses.
module ram_wr_burst_16 #(
  parameter int DWIDTH = fc_ram_pkg::DWIDTH,
  parameter int AWIDTH = fc_ram_pkg::AWIDTH,
  parameter int NWORDS = fc_ram_pkg::NWORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*DWIDTH-1:0] in_data,
  input  logic                     use_ptr,
  input  logic [AWIDTH-1:0]        base_addr,
  input  logic                     ptr_clr,
  output logic                     wren,
  output logic [AWIDTH-1:0]        waddr,
  output logic [DWIDTH-1:0]        din,
  output logic                     busy,
  output logic                     done,
  output logic [AWIDTH-1:0]        wr_ptr
);
  import fc_ram_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(NWORDS - 1);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        cnt_r;
  logic [AWIDTH-1:0] base_r;
  logic [AWIDTH-1:0] waddr_r;
  logic [AWIDTH-1:0] wr_ptr_r;
  logic [AWIDTH-1:0] sel_base_s;
  logic              wren_r;
  logic              busy_r;
  logic              done_r;
  logic              ready_r;
  logic              accept_s;
  logic              last_s;

  // ready_r is only ever set while in IDLE, so it qualifies the handshake
  assign accept_s   = in_valid & ready_r;
  assign last_s     = (state_r == WRITE) && (cnt_r == CNT_LAST);
  assign sel_base_s = use_ptr ? wr_ptr_r : base_addr;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = WRITE;
        else          state_s = IDLE;
      end
      WRITE: begin
        if (last_s) state_s = DONE;
        else        state_s = WRITE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered handshake/status outputs, burst address and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wren_r  <= 1'b0;
      waddr_r <= {AWIDTH{1'b0}};
      base_r  <= {AWIDTH{1'b0}};
      cnt_r   <= 4'd0;
    end else begin
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        base_r  <= sel_base_s;
        waddr_r <= sel_base_s;
        wren_r  <= 1'b1;
        cnt_r   <= 4'd0;
      end else if (state_r == WRITE) begin
        cnt_r   <= cnt_r + 4'd1;
        waddr_r <= waddr_r + AWIDTH'(1);
        wren_r  <= ~last_s;
      end
    end
  end

  // Running pointer: clear has priority over the end-of-burst advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AWIDTH{1'b0}};
    end else if (ptr_clr) begin
      wr_ptr_r <= {AWIDTH{1'b0}};
    end else if (state_r == DONE) begin
      wr_ptr_r <= base_r + AWIDTH'(NWORDS);
    end
  end

  ram_wr_shreg u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_s),
    .shift     (state_r == WRITE),
    .load_data (in_data),
    .head      (din)
  );

  assign in_ready = ready_r;
  assign wren     = wren_r;
  assign waddr    = waddr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_ptr   = wr_ptr_r;

endmodule

// File: tb/tb_ram_wr_burst_16.sv
// Directed self-checking bench for ram_wr_burst_16 with a behavioural RAM
// capturing every write for the window-read check.
module tb_ram_wr_burst_16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         use_ptr;
  logic [7:0]   base_addr;
  logic         ptr_clr;
  logic         wren;
  logic [7:0]   waddr;
  logic [15:0]  din;
  logic         busy;
  logic         done;
  logic [7:0]   wr_ptr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren) mem[waddr] <= din;
  end

  ram_wr_burst_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .use_ptr   (use_ptr),
    .base_addr (base_addr),
    .ptr_clr   (ptr_clr),
    .wren      (wren),
    .waddr     (waddr),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .wr_ptr    (wr_ptr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] dbase);
    for (int k = 0; k < 16; k++) in_data[k*16 +: 16] = dbase + 16'(k);
  endtask

  // Handshake from an IDLE sample point; inputs are scrambled after the edge
  task automatic accept_burst(input logic up, input logic [7:0] base, input logic [15:0] dbase);
    fill(dbase);
    use_ptr   = up;
    base_addr = base;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_data   = {256{1'b1}};
    base_addr = 8'hFF;
    use_ptr   = ~up;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    ptr_clr = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; ptr_clr = 1'b0; use_ptr = 1'b0;
    base_addr = 8'h00; in_data = '0;
    step();
    checks++;
    if ({wren, busy, done, in_ready} !== 4'b0000 || waddr !== 8'h00 || din !== 16'h0000 || wr_ptr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: wren=%b busy=%b done=%b rdy=%b waddr=%h din=%h ptr=%h expected all zero",
               wren, busy, done, in_ready, waddr, din, wr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_explicit();
    logic [7:0] ea;
    accept_burst(1'b0, 8'h20, 16'h1000);
    for (int k = 0; k < 16; k++) begin
      ea = 8'h20 + 8'(k);
      checks++;
      if (wren !== 1'b1 || waddr !== ea || din !== 16'h1000 + 16'(k)) begin
        errors++;
        $display("FAIL explicit_word%0d: wren=%b waddr=%h din=%h expected 1 %h %h",
                 k, wren, waddr, din, ea, 16'h1000 + 16'(k));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || wren !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL explicit_done: done=%b wren=%b busy=%b rdy=%b expected 1 0 1 0", done, wren, busy, in_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || wr_ptr !== 8'h30) begin
      errors++;
      $display("FAIL explicit_after: done=%b busy=%b rdy=%b ptr=%h expected 0 0 1 30", done, busy, in_ready, wr_ptr);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int n = 0;
    int low = 0;
    logic ready_pre;
    logic [15:0] ed;
    apply_reset();
    use_ptr = 1'b1;
    fill(16'h00A0);
    in_valid = 1'b1;
    ready_pre = in_ready;
    for (int i = 0; i < 45; i++) begin
      logic vld_pre;
      vld_pre = in_valid;
      step();
      if (ready_pre && vld_pre) begin
        acc++;
        if (acc == 1) fill(16'h00B0);
        else in_valid = 1'b0;
      end
      if (wren === 1'b1) begin
        ed = (n < 16) ? 16'h00A0 + 16'(n) : 16'h00B0 + 16'(n - 16);
        checks++;
        if (waddr !== 8'(n) || din !== ed) begin
          errors++;
          $display("FAIL b2b_write%0d: waddr=%h din=%h expected %h %h", n, waddr, din, 8'(n), ed);
        end
        n++;
      end
      if (acc == 1 && in_ready === 1'b0) low++;
      ready_pre = in_ready;
    end
    checks++;
    if (n != 32 || acc != 2) begin
      errors++;
      $display("FAIL b2b_counts: writes=%0d accepts=%0d expected 32 2", n, acc);
    end
    checks++;
    if (low != 17) begin
      errors++;
      $display("FAIL b2b_ready_gap: got %0d expected 17", low);
    end
    checks++;
    if (wr_ptr !== 8'h20) begin
      errors++;
      $display("FAIL b2b_ptr: got %h expected 20", wr_ptr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    logic ok;
    accept_burst(1'b0, 8'd250, 16'h5A00);
    for (int k = 0; k < 16; k++) begin
      ea = 8'(250 + k);
      checks++;
      if (wren !== 1'b1 || waddr !== ea || din !== 16'h5A00 + 16'(k)) begin
        errors++;
        $display("FAIL wrap_word%0d: wren=%b waddr=%0d din=%h expected 1 %0d %h",
                 k, wren, waddr, din, ea, 16'h5A00 + 16'(k));
      end
      step();
    end
    step();
    checks++;
    if (wr_ptr !== 8'd10) begin
      errors++;
      $display("FAIL wrap_ptr: got %0d expected 10", wr_ptr);
    end
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ea = 8'(250 + k);
      if (mem[ea] !== 16'h5A00 + 16'(k)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_window_read: got mem[250]=%h mem[9]=%h expected 5a00 5a0f", mem[250], mem[9]);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] ea;
    logic quiet;
    accept_burst(1'b0, 8'h60, 16'h7000);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        fill(16'h9000);
        base_addr = 8'h00;
        use_ptr = 1'b0;
        in_valid = 1'b1;
      end
      if (k == 5) in_valid = 1'b0;
      ea = 8'h60 + 8'(k);
      checks++;
      if (wren !== 1'b1 || waddr !== ea || din !== 16'h7000 + 16'(k) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_word%0d: wren=%b waddr=%h din=%h rdy=%b expected 1 %h %h 0",
                 k, wren, waddr, din, in_ready, ea, 16'h7000 + 16'(k));
      end
      step();
    end
    step();
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wren !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++;
    if (!quiet || wr_ptr !== 8'h70) begin
      errors++;
      $display("FAIL ignore_no_queue: quiet=%b ptr=%h expected 1 70", quiet, wr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet;
    accept_burst(1'b0, 8'h80, 16'h3300);
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (wren !== 1'b1 || waddr !== 8'h85) begin
      errors++;
      $display("FAIL midrst_k5: wren=%b waddr=%h expected 1 85", wren, waddr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || din !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async: wren=%b busy=%b din=%h expected 0 0 0000", wren, busy, din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || wr_ptr !== 8'h00) begin
      errors++;
      $display("FAIL midrst_release: rdy=%b ptr=%h expected 1 00", in_ready, wr_ptr);
    end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || wren !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL midrst_no_done: got activity expected none");
    end
  endtask

  task automatic test_ptr_clr();
    logic [7:0] ea;
    accept_burst(1'b0, 8'h30, 16'h0100);
    for (int i = 0; i < 17; i++) step();
    checks++;
    if (wr_ptr !== 8'h40) begin
      errors++;
      $display("FAIL clr_setup_ptr: got %h expected 40", wr_ptr);
    end
    ptr_clr = 1'b1;
    accept_burst(1'b1, 8'h00, 16'h0C00);
    ptr_clr = 1'b0;
    checks++;
    if (wr_ptr !== 8'h00) begin
      errors++;
      $display("FAIL clr_at_accept: ptr=%h expected 00", wr_ptr);
    end
    for (int k = 0; k < 16; k++) begin
      ea = 8'h40 + 8'(k);
      checks++;
      if (wren !== 1'b1 || waddr !== ea || din !== 16'h0C00 + 16'(k)) begin
        errors++;
        $display("FAIL clr_word%0d: wren=%b waddr=%h din=%h expected 1 %h %h",
                 k, wren, waddr, din, ea, 16'h0C00 + 16'(k));
      end
      step();
    end
    ptr_clr = 1'b1;
    step();
    ptr_clr = 1'b0;
    checks++;
    if (wr_ptr !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_at_done: ptr=%h rdy=%b expected 00 1", wr_ptr, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_back_to_back();
    test_wrap();
    test_ignore();
    test_reset_mid();
    test_ptr_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
